node_feeder: RTL
================

# node_feeder

Input sequencer that drives a single neural-network node. Accepts one sample vector of `NUM_INPUTS` 16-bit words over a valid/ready stream and buffers it. It then walks the node's input index from 0 to `NUM_INPUTS-1`, one term per cycle, presenting the buffered word alongside accumulate strobes. After the node's result latency it captures the node result and offers it on a valid/ready output. It sits between the sample source and each `node` instance and supplies the index and data that the node consumes.

## Interface

- `NUM_INPUTS`, 64: words per sample vector; also the number of accumulate cycles.
- `DATA_W`, 16: width of each input word.
- `IDX_W`, 7: width of `cnt_val`; must satisfy 2^IDX_W > NUM_INPUTS-1.
- `RES_W`, 16: width of the node result.
- `RESULT_LAT`, 2: cycles from the last accumulate strobe to a valid `node_result`; minimum 1.

- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `abort`  in  1  synchronous flush; discards the current vector or result.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  feeder can accept a word.
- `in_data`  in  DATA_W  input word; written to the buffer at `wr_ptr`.
- `cnt_val`  out  IDX_W  term index to the node.
- `data_out`  out  DATA_W  buffered word at `cnt_val`; combinational read.
- `acc_en`  out  1  node adds the product for this term.
- `acc_first`  out  1  node loads the product for this term instead of adding (index 0).
- `node_result`  in  RES_W  node output; sampled once per vector.
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  RES_W  captured result.
- `busy`  out  1  high in RUN and DRAIN.

## Operation

- Buffer: `NUM_INPUTS` x `DATA_W` registers. Write pointer `wr_ptr` ranges 0..`NUM_INPUTS-1`. Run counter `cnt` ranges 0..`NUM_INPUTS-1`. Drain counter ranges 0..`RESULT_LAT-1`.
- **LOAD** (reset state)
  - `in_ready`=1.
  - Each cycle with `in_valid`&&`in_ready` writes `buf[wr_ptr]` and increments `wr_ptr`.
  - A write with `wr_ptr`==`NUM_INPUTS-1` sets `wr_ptr` to 0, sets `cnt` to 0, and moves to RUN.
- **RUN**
  - `acc_en`=1, `cnt_val`=`cnt`, `data_out`=`buf[cnt]`, `acc_first`=(`cnt`==0).
  - `cnt` increments each cycle.
  - At `cnt`==`NUM_INPUTS-1`, moves to DRAIN with the drain counter at 0.
- **DRAIN**
  - `acc_en`=0.
  - After `RESULT_LAT` cycles, the final DRAIN edge loads `out_data`<=`node_result`, sets `out_valid`<=1, and moves to DONE.
- **DONE**
  - `out_valid`=1; `out_data` holds stable.
  - `out_valid`&&`out_ready` clears `out_valid` and moves to LOAD.
- Outside RUN: `cnt_val`=0, `acc_en`=0, `acc_first`=0, `data_out`=`buf[0]`.
- `in_ready`=(state==LOAD)&&!`rst`. `in_valid` outside LOAD is ignored and writes nothing.
- `busy`=(state==RUN||state==DRAIN).
- No arithmetic on data: words pass unmodified, and `out_data` is an exact copy of `node_result`.

## Timing

- Reset (`rst` high at an edge): state=LOAD, `wr_ptr`=0, `cnt`=0, drain counter=0, `out_valid`=0, `out_data`=0. Therefore `cnt_val`=0, `acc_en`=0, `acc_first`=0, `busy`=0. `in_ready`=0 while `rst` is high and 1 on the first cycle after release. Buffer contents are not reset.
- Priority: `rst` > `abort` > normal operation.
- `abort` in any state has the same effect as reset except the buffer keeps its contents. It applies mid-LOAD (partial vector discarded), mid-RUN (node sees no more strobes), DRAIN, and DONE (`out_valid` drops with no handshake).
- Latency, with the last input word accepted at edge of cycle T:
  - RUN occupies cycles T+1..T+NUM_INPUTS (`cnt_val` 0..`NUM_INPUTS-1`).
  - DRAIN occupies the next `RESULT_LAT` cycles.
  - `out_valid` first high in cycle T+NUM_INPUTS+RESULT_LAT+1. With defaults: T+67.
- Throughput: one vector per at least `NUM_INPUTS`+`NUM_INPUTS`+`RESULT_LAT`+1 cycles. LOAD and RUN do not overlap.
- Handshake rules:
  - A handshake accepted in DONE moves the state to LOAD next cycle, so `in_ready` rises one cycle after the `out_valid` handshake, never in the same cycle.
  - `out_valid` never drops without `out_ready`, `abort`, or `rst`.
- Input stalls: `in_valid` low in LOAD holds `wr_ptr`. Gaps are allowed anywhere in a vector.

## Test plan

- Reset, then stream words 1..64 back-to-back with `in_valid`=1 and `out_ready`=1 -> `in_ready` drops after word 64. `cnt_val` steps 0..63 with `data_out`=`cnt_val`+1. `acc_first` is high only at index 0. `acc_en` is high for exactly 64 cycles. With `node_result` held at 0x1234, `out_valid` rises in cycle T+67 with `out_data`=0x1234.
- Random `in_valid` gaps during LOAD -> buffer order is preserved: `data_out` at index k equals the k-th accepted word.
- `out_ready`=0 for 10 cycles in DONE -> `out_valid` stays 1, `out_data` stays stable, and `in_ready` stays 0. Raising `out_ready` gives `in_ready`=1 on the next cycle.
- `abort` after 30 words, then 64 new words -> the second vector's words appear at indices 0..63. None of the first vector's words appear.
- `abort` at `cnt_val`=40 in RUN -> `acc_en`=0 the next cycle, state is LOAD, and `out_valid` never rises.
- `rst` asserted in DONE with `out_valid`=1 -> `out_valid`=0 and `out_data`=0 next cycle. `in_ready`=1 after `rst` releases.

Source files
------------

// File: rtl/node_feeder.sv
// node_feeder: buffers one sample vector, walks it into a node term by term,
// then captures the node result and offers it downstream over valid/ready.
module node_feeder #(
    parameter int NUM_INPUTS = 64,
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 7,
    parameter int RES_W      = 16,
    parameter int RESULT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [IDX_W-1:0]  cnt_val,
    output logic [DATA_W-1:0] data_out,
    output logic              acc_en,
    output logic              acc_first,
    input  logic [RES_W-1:0]  node_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic              busy
);
    localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int DW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic [DW-1:0]    LAST_DRN = DW'(RESULT_LAT - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  cnt;
    logic [DW-1:0]     drn;
    logic [DATA_W-1:0] mem [NUM_INPUTS];
    logic              wr_en;
    logic              running;

    assign running   = (state == S_RUN);
    assign in_ready  = (state == S_LOAD) && !rst;
    assign wr_en     = in_valid && in_ready && !abort;
    assign cnt_val   = running ? cnt : '0;
    assign data_out  = mem[cnt_val[AW-1:0]];
    assign acc_en    = running;
    assign acc_first = running && (cnt == '0);
    assign busy      = running || (state == S_DRAIN);

    // Vector storage is deliberately left out of reset and abort.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state     <= S_LOAD;
            wr_ptr    <= '0;
            cnt       <= '0;
            drn       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (wr_en) begin
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr <= '0;
                            cnt    <= '0;
                            state  <= S_RUN;
                        end else begin
                            wr_ptr <= wr_ptr + IDX_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        drn   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drn == LAST_DRN) begin
                        drn       <= '0;
                        out_data  <= node_result;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        drn <= drn + DW'(1);
                    end
                end
                S_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
